// File: rtl/red_pitaya_xadc_drp_arb.sv
// XADC DRP arbiter: shares one DRP port between EOC auto-readout and
// software accesses, alternating grants, with a DRDY watchdog.
module red_pitaya_xadc_drp_arb #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        eoc_i,
  input  logic [4:0]  channel_i,
  input  logic        sw_req_i,
  input  logic        sw_we_i,
  input  logic [6:0]  sw_addr_i,
  input  logic [15:0] sw_wdata_i,
  output logic        sw_ack_o,
  output logic        sw_err_o,
  output logic [15:0] sw_rdata_o,
  output logic        smp_valid_o,
  output logic [4:0]  smp_chan_o,
  output logic [11:0] smp_data_o,
  output logic        overrun_o,
  input  logic        ovr_clr_i,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic        r_eoc_pend, r_sw_pend;
  logic [4:0]  r_eoc_chan;
  logic        r_sw_we;
  logic [6:0]  r_sw_addr;
  logic [15:0] r_sw_wdata;
  logic        r_last_sw, r_gnt_sw, r_gnt_we;
  logic [TW-1:0] r_wd;

  logic        r_ack, r_err, r_smp_valid, r_ovr;
  logic [15:0] r_rdata;
  logic [4:0]  r_smp_chan;
  logic [11:0] r_smp_data;
  logic        r_den, r_dwe;
  logic [6:0]  r_daddr;
  logic [15:0] r_di;

  logic w_gnt, w_gnt_sw, w_gnt_eoc;
  logic w_drdy, w_tmo, w_sw_busy, w_sw_rej, w_ovr_set;

  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_sw = 1'b0;
    if (r_state == S_IDLE && (r_eoc_pend || r_sw_pend)) begin
      w_gnt = 1'b1;
      // both pending: hand the port to whoever did not have it last
      if (r_eoc_pend && r_sw_pend) w_gnt_sw = !r_last_sw;
      else                         w_gnt_sw = r_sw_pend;
    end
  end

  assign w_gnt_eoc = w_gnt && !w_gnt_sw;
  assign w_drdy    = (r_state == S_WAIT) && drp_drdy_i;
  assign w_tmo     = (r_state == S_WAIT) && !drp_drdy_i
                     && (r_wd == TW'(TIMEOUT - 1));
  assign w_sw_busy = r_gnt_sw && (r_state != S_IDLE);
  assign w_sw_rej  = sw_req_i && (r_sw_pend || w_sw_busy);
  assign w_ovr_set = (eoc_i && r_eoc_pend && !w_gnt_eoc)
                     || (w_tmo && !r_gnt_sw);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_gnt) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (w_drdy)     w_next = S_DONE;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_eoc_pend  <= 1'b0;
      r_sw_pend   <= 1'b0;
      r_eoc_chan  <= '0;
      r_sw_we     <= 1'b0;
      r_sw_addr   <= '0;
      r_sw_wdata  <= '0;
      r_last_sw   <= 1'b1;
      r_gnt_sw    <= 1'b0;
      r_gnt_we    <= 1'b0;
      r_wd        <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_smp_valid <= 1'b0;
      r_smp_chan  <= '0;
      r_smp_data  <= '0;
      r_ovr       <= 1'b0;
      r_den       <= 1'b0;
      r_dwe       <= 1'b0;
      r_daddr     <= '0;
      r_di        <= '0;
    end else begin
      r_state     <= w_next;
      r_ack       <= 1'b0;
      r_err       <= w_sw_rej;
      r_smp_valid <= 1'b0;
      r_den       <= 1'b0;
      r_dwe       <= 1'b0;

      if (w_gnt_eoc) r_eoc_pend <= 1'b0;
      if (eoc_i) begin
        r_eoc_pend <= 1'b1;
        r_eoc_chan <= channel_i;
      end
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (ovr_clr_i) r_ovr <= 1'b0;

      if (w_gnt && w_gnt_sw) r_sw_pend <= 1'b0;
      if (sw_req_i && !w_sw_rej) begin
        r_sw_pend  <= 1'b1;
        r_sw_we    <= sw_we_i;
        r_sw_addr  <= sw_addr_i;
        r_sw_wdata <= sw_wdata_i;
      end

      if (w_gnt) begin
        r_gnt_sw  <= w_gnt_sw;
        r_last_sw <= w_gnt_sw;
        r_gnt_we  <= w_gnt_sw && r_sw_we;
        r_den     <= 1'b1;
        r_dwe     <= w_gnt_sw && r_sw_we;
        r_daddr   <= w_gnt_sw ? r_sw_addr : {2'b00, r_eoc_chan};
        r_di      <= w_gnt_sw ? r_sw_wdata : 16'h0000;
      end

      if (r_state == S_ISSUE)     r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + TW'(1);

      if (w_drdy) begin
        if (r_gnt_sw) begin
          r_ack   <= 1'b1;
          r_rdata <= r_gnt_we ? 16'h0000 : drp_do_i;
        end else begin
          r_smp_valid <= 1'b1;
          r_smp_chan  <= r_daddr[4:0];
          r_smp_data  <= drp_do_i[15:4];
        end
      end
      if (w_tmo && r_gnt_sw) begin
        r_ack   <= 1'b1;
        r_err   <= 1'b1;
        r_rdata <= 16'h0000;
      end
    end
  end

  assign sw_ack_o    = r_ack;
  assign sw_err_o    = r_err;
  assign sw_rdata_o  = r_rdata;
  assign smp_valid_o = r_smp_valid;
  assign smp_chan_o  = r_smp_chan;
  assign smp_data_o  = r_smp_data;
  assign overrun_o   = r_ovr;
  assign drp_den_o   = r_den;
  assign drp_dwe_o   = r_dwe;
  assign drp_daddr_o = r_daddr;
  assign drp_di_o    = r_di;

endmodule
